// File: rtl/imem_port_pkg.sv
// Shared core types: instruction word and the instruction-fetch port FSM states.
package common;

    typedef logic [31:0] instruction_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } imem_state_type;

endpackage

// File: rtl/imem_port_if.sv
// Instruction-memory bus: one request/grant handshake followed by a single rvalid beat.
interface imem_port_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/imem_port.sv
// Instruction fetch port: one-entry line buffer in front of a single-outstanding memory bus,
// with critical-word forwarding on the response cycle and fence.i invalidation.
module imem_port
    import common::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      address,
    input  logic             invalidate,
    output instruction_type  data,
    output logic             fetch_valid,
    output logic             stall,
    output logic [31:0]      miss_count,
    imem_port_if.master      mem
);

    imem_state_type  r_state;
    imem_state_type  w_next;
    logic            r_line_valid;
    logic [29:0]     r_line_tag;
    instruction_type r_line_data;
    logic [29:0]     r_req_tag;
    logic            r_inv_pending;
    logic [31:0]     r_miss_count;

    logic [29:0]     w_tag;
    logic [29:0]     w_req_tag;
    logic            w_hit;
    logic            w_fill;
    logic            w_unused;

    assign w_tag    = address[31:2];
    assign w_unused = ^address[1:0];
    assign w_hit    = r_line_valid && (r_line_tag == w_tag);
    assign w_fill   = reset_n && (r_state == WAIT) && mem.mem_rvalid;

    // In IDLE the request goes out the same cycle, before req_tag is registered.
    assign w_req_tag    = (r_state == IDLE) ? w_tag : r_req_tag;
    assign mem.mem_addr = {w_req_tag, 2'b00};
    assign stall        = !fetch_valid;
    assign miss_count   = r_miss_count;

    always_comb begin
        w_next      = r_state;
        mem.mem_req = 1'b0;
        fetch_valid = 1'b0;
        data        = '0;
        if (reset_n) begin
            unique case (r_state)
                IDLE: begin
                    if (invalidate) begin
                        w_next = IDLE;
                    end else if (w_hit) begin
                        fetch_valid = 1'b1;
                        data        = r_line_data;
                    end else begin
                        mem.mem_req = 1'b1;
                        w_next      = mem.mem_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_gnt) w_next = WAIT;
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        w_next = IDLE;
                        if (r_req_tag == w_tag) begin
                            fetch_valid = 1'b1;
                            data        = mem.mem_rdata;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_line_valid  <= 1'b0;
            r_line_tag    <= '0;
            r_line_data   <= '0;
            r_req_tag     <= '0;
            r_inv_pending <= 1'b0;
            r_miss_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && mem.mem_req) r_req_tag <= w_tag;
            if (mem.mem_req && mem.mem_gnt) r_miss_count <= r_miss_count + 32'd1;
            if (invalidate) r_line_valid <= 1'b0;
            // A fill whose request predates a fence.i must not make the line valid.
            if (w_fill) begin
                r_line_tag    <= r_req_tag;
                r_line_data   <= mem.mem_rdata;
                r_line_valid  <= !(r_inv_pending || invalidate);
                r_inv_pending <= 1'b0;
            end else if (invalidate && r_state == WAIT) begin
                r_inv_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_port.sv
// Bench for imem_port: directed fetch scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_imem_port;
    import common::*;

    logic            clk;
    logic            reset_n;
    logic [31:0]     address;
    logic            invalidate;
    instruction_type data;
    logic            fetch_valid;
    logic            stall;
    logic [31:0]     miss_count;

    imem_port_if bus ();

    imem_port dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .address     (address),
        .invalidate  (invalidate),
        .data        (data),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .miss_count  (miss_count),
        .mem         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: one line of cache plus a description of the request in flight.
    bit          m_busy;
    bit          m_granted;
    bit [29:0]   m_rt;
    bit          m_lv;
    bit [29:0]   m_lt;
    bit [31:0]   m_ld;
    bit          m_pend;
    bit [31:0]   m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic inv, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rstn);
        bit        e_req, e_fv;
        bit [31:0] e_data, e_addr;
        bit [29:0] tag;
        @(negedge clk);
        address        = a;
        invalidate     = inv;
        bus.mem_gnt    = gnt;
        bus.mem_rvalid = rv;
        bus.mem_rdata  = rd;
        reset_n        = rstn;
        #1;
        tag    = a[31:2];
        e_req  = 1'b0;
        e_fv   = 1'b0;
        e_data = 32'h0;
        e_addr = 32'h0;
        if (rstn) begin
            if (!m_busy) begin
                if (inv) begin
                    e_fv = 1'b0;
                end else if (m_lv && m_lt == tag) begin
                    e_fv   = 1'b1;
                    e_data = m_ld;
                end else begin
                    e_req  = 1'b1;
                    e_addr = {tag, 2'b00};
                end
            end else if (!m_granted) begin
                e_req  = 1'b1;
                e_addr = {m_rt, 2'b00};
            end else if (rv && m_rt == tag) begin
                e_fv   = 1'b1;
                e_data = rd;
            end
        end
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e_fv});
        chk("stall", {31'b0, stall}, {31'b0, !e_fv});
        chk("mem_req", {31'b0, bus.mem_req}, {31'b0, e_req});
        chk("miss_count", miss_count, m_count);
        if (e_fv || !rstn) chk("data", data, e_data);
        if (e_req) chk("mem_addr", bus.mem_addr, e_addr);
        @(posedge clk);
        if (!rstn) begin
            m_busy = 0; m_granted = 0; m_lv = 0; m_pend = 0; m_rt = '0; m_count = 0;
        end else begin
            if (e_req && gnt) m_count++;
            if (inv) m_lv = 0;
            if (!m_busy) begin
                if (e_req) begin
                    m_busy = 1; m_rt = tag; m_granted = gnt;
                end
            end else if (!m_granted) begin
                if (gnt) m_granted = 1;
            end else if (rv) begin
                m_lt = m_rt; m_ld = rd; m_lv = !(m_pend || inv);
                m_pend = 0; m_busy = 0; m_granted = 0;
            end else if (inv) begin
                m_pend = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] addrs [8];
        addrs = '{32'h0, 32'h2, 32'h4, 32'h6, 32'h40, 32'h42, 32'h80, 32'h1000};
        m_busy = 0; m_granted = 0; m_rt = '0; m_lv = 0; m_lt = '0; m_ld = '0;
        m_pend = 0; m_count = 0;
        address = '0; invalidate = 0; reset_n = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;

        cyc(32'h0, 0, 0, 0, 32'h0, 0);
        cyc(32'h0, 0, 0, 0, 32'h0, 0);

        // Cold miss: request over two cycles, forwarded on the response cycle.
        cyc(32'h0, 0, 0, 0, 32'h0, 1);
        cyc(32'h0, 0, 1, 0, 32'h0, 1);
        cyc(32'h0, 0, 0, 1, 32'h00000013, 1);
        #1 chk("cold_miss_count", miss_count, 32'd1);

        // Halfword address in the same word hits the line.
        cyc(32'h2, 0, 0, 0, 32'h0, 1);
        #1 chk("hw_hit_count", miss_count, 32'd1);

        // Grant held off for three cycles.
        cyc(32'h100, 0, 0, 0, 32'h0, 1);
        cyc(32'h104, 0, 0, 0, 32'h0, 1);
        cyc(32'h108, 0, 0, 0, 32'h0, 1);
        cyc(32'h100, 0, 1, 0, 32'h0, 1);
        cyc(32'h100, 0, 0, 0, 32'h0, 1);
        cyc(32'h100, 0, 0, 1, 32'hCAFE0001, 1);

        // Redirect while waiting for the response.
        cyc(32'h40, 0, 1, 0, 32'h0, 1);
        cyc(32'h80, 0, 0, 0, 32'h0, 1);
        cyc(32'h80, 0, 0, 1, 32'h11110040, 1);
        cyc(32'h80, 0, 1, 0, 32'h0, 1);
        cyc(32'h80, 0, 0, 1, 32'h22220080, 1);
        #1 chk("redirect_count", miss_count, 32'd4);

        // fence.i while waiting: forwarded, but the line stays invalid.
        cyc(32'h200, 0, 1, 0, 32'h0, 1);
        cyc(32'h200, 1, 0, 0, 32'h0, 1);
        cyc(32'h200, 0, 0, 1, 32'h33330200, 1);
        cyc(32'h200, 0, 1, 0, 32'h0, 1);
        cyc(32'h200, 0, 0, 1, 32'h33330200, 1);
        cyc(32'h200, 0, 0, 0, 32'h0, 1);
        cyc(32'h200, 1, 0, 0, 32'h0, 1);

        // Reset mid-WAIT, then a stray response.
        cyc(32'h300, 0, 1, 0, 32'h0, 1);
        cyc(32'h300, 0, 0, 0, 32'h0, 0);
        cyc(32'h300, 0, 0, 1, 32'h44440300, 1);
        cyc(32'h300, 0, 0, 1, 32'h44440300, 1);
        #1 chk("reset_wait_count", miss_count, 32'd0);

        for (int i = 0; i < 600; i++) begin
            cyc(addrs[$urandom_range(7)],
                ($urandom_range(19) == 0),
                ($urandom_range(1) == 1),
                ($urandom_range(9) < 4),
                $urandom,
                ($urandom_range(99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port.md
IMEM_PORT -- requirements
Module: imem_port

Interface
REQ-001 SHALL have ports: clk  input  1  core clock; reset_n  input  1  reset, synchronous, active-low (sampled on rising clk).
REQ-002 SHALL have: address  input  32  byte fetch address from fetch stage (may be halfword-aligned, e.g. pc+2).
REQ-003 SHALL have: invalidate  input  1  one-cycle pulse, clears line buffer (fence.i).
REQ-004 SHALL have: data  output  32 (instruction_type from common)  word containing address, valid when fetch_valid=1.
REQ-005 SHALL have: fetch_valid  output  1  data valid this cycle; stall  output  1  equals !fetch_valid, gates pc_write upstream.
REQ-006 SHALL have memory-side: mem_req  output  1; mem_addr  output  32  word-aligned; mem_gnt  input  1; mem_rvalid  input  1; mem_rdata  input  32.
REQ-007 SHALL have: miss_count  output  32  number of memory requests granted since reset.

Function
REQ-008 Tag SHALL be address[31:2]; mem_addr SHALL always be {req_tag, 2'b00}.
REQ-009 One-entry line buffer (line_valid, line_tag, line_data) SHALL be held.
REQ-010 Hit (line_valid && line_tag==address[31:2]) SHALL give data=line_data, fetch_valid=1 combinationally, zero added latency, no memory request.
REQ-011 FSM states SHALL be IDLE, REQ, WAIT.
REQ-012 IDLE, miss: mem_req=1 same cycle, req_tag<=address[31:2]; mem_gnt=1 same cycle -> WAIT, else -> REQ.
REQ-013 REQ: mem_req=1, mem_addr held stable (from req_tag) until mem_gnt regardless of address changes; mem_gnt -> WAIT.
REQ-014 WAIT: mem_req=0; on mem_rvalid -> line_tag<=req_tag, line_data<=mem_rdata, line_valid<=1, -> IDLE.
REQ-015 Forwarding: in WAIT with mem_rvalid=1 and req_tag==address[31:2], data=mem_rdata, fetch_valid=1 that cycle.
REQ-016 In WAIT with mem_rvalid=1 and req_tag!=address[31:2] (redirect during miss), fetch_valid=0; response still fills line; new miss issued from IDLE next cycle.
REQ-017 mem_rvalid outside WAIT SHALL be ignored.
REQ-018 At most one outstanding request; no request issued in REQ/WAIT for a different tag.
REQ-019 invalidate in IDLE/REQ: line_valid<=0 next cycle; fetch_valid=0 in the invalidate cycle.
REQ-020 invalidate in WAIT: response forwarded per REQ-015 but SHALL NOT set line_valid; pending-invalidate flag cleared on return to IDLE.
REQ-021 invalidate coincident with a hit: fetch_valid=0 that cycle; refetch next cycle.
REQ-022 miss_count SHALL increment by 1 on each cycle with mem_req && mem_gnt, wrapping 0xFFFFFFFF->0.
REQ-023 Worst-case miss latency with gnt and rvalid each one cycle after request SHALL be 2 cycles stall (forward on rvalid cycle).

Reset
REQ-024 On reset_n=0 at rising clk: state=IDLE, line_valid=0, pending-invalidate=0, req_tag=0, miss_count=0.
REQ-025 During reset: mem_req=0, fetch_valid=0, stall=1, data=0.
REQ-026 Reset mid-WAIT SHALL abandon the request; memory is reset with the core so no late response is expected; any late mem_rvalid is ignored per REQ-017.

Structure
REQ-027 instruction_type SHALL come from package common; FSM enum imem_state_type SHALL be added to common.
REQ-028 No sub-module; single module, line buffer and FSM inline.

Verification
REQ-029 Cold miss: reset, address=0x0, gnt next cycle, rvalid+rdata=0x00000013 one cycle later -> mem_req at cycle 0 and 1, fetch_valid=1 data=0x00000013 at cycle 2, miss_count=1.
REQ-030 Halfword hit: after REQ-029, address=0x2 -> fetch_valid=1 same cycle, mem_req=0, miss_count unchanged.
REQ-031 Held gnt: address=0x100, mem_gnt low 3 cycles -> mem_addr=0x100 constant and mem_req=1 throughout, stall=1 until rvalid.
REQ-032 Redirect during WAIT: miss at 0x40, address changes to 0x80 before rvalid -> fetch_valid=0 on rvalid, line_tag=0x40>>2, new request to 0x80 next cycle, miss_count=2.
REQ-033 Invalidate during WAIT: miss 0x200, invalidate pulse in WAIT -> data forwarded on rvalid, next cycle address=0x200 misses again (mem_req=1).
REQ-034 Reset mid-WAIT then spurious mem_rvalid -> line_valid stays 0, fetch_valid=0, miss_count=0.
